// File: rtl/ctrl_pkg.sv
// Shared constants, state encoding and control-vector type for the multi-cycle controller.
package ctrl_pkg;

    localparam int unsigned OP_RTYPE = 1;
    localparam int unsigned OP_LOAD  = 2;
    localparam int unsigned OP_STORE = 3;
    localparam int unsigned OP_BEQ   = 4;
    localparam int unsigned OP_ADDI  = 5;

    localparam logic [7:0] ALU_ADD = 8'h20;
    localparam logic [7:0] ALU_SUB = 8'h22;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd6
    } state_e;

    typedef struct packed {
        logic imem_req;
        logic ir_write;
        logic pc_write;
        logic reg_dst;
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_write;
    } ctrl_t;

    // Opcodes outside RTYPE..ADDI are undefined and trap in DECODE.
    function automatic logic op_legal(input logic [31:0] op);
        return (op >= 32'(OP_RTYPE)) && (op <= 32'(OP_ADDI));
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_control_if #(
    parameter int unsigned OPCODE_W = 8,
    parameter int unsigned ALUOP_W  = 8
);
    logic [OPCODE_W-1:0] opcode;
    logic                imem_ready;
    logic                dmem_ready;
    logic                trap_clear;
    logic                imem_req;
    logic                irWrite;
    logic                pcWrite;
    logic                regDst;
    logic                branch;
    logic                memRead;
    logic                memToReg;
    logic [ALUOP_W-1:0]  aluOp;
    logic                memWrite;
    logic                aluSrc;
    logic                regWrite;
    logic                illegal;
    logic                bus_error;
    logic [2:0]          state_o;

    modport master (
        input  opcode, imem_ready, dmem_ready, trap_clear,
        output imem_req, irWrite, pcWrite, regDst, branch, memRead, memToReg,
               aluOp, memWrite, aluSrc, regWrite, illegal, bus_error, state_o
    );

    modport slave (
        output opcode, imem_ready, dmem_ready, trap_clear,
        input  imem_req, irWrite, pcWrite, regDst, branch, memRead, memToReg,
               aluOp, memWrite, aluSrc, regWrite, illegal, bus_error, state_o
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational control decode: (state, latched opcode) -> datapath control vector.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 8,
    parameter int unsigned ALUOP_W  = 8
) (
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                imem_ready_i,
    output ctrl_t               ctrl_c_o,
    output logic [ALUOP_W-1:0]  alu_op_c_o
);

    logic is_rtype, is_load, is_store, is_beq, is_addi;

    assign is_rtype = (opcode_i == OPCODE_W'(OP_RTYPE));
    assign is_load  = (opcode_i == OPCODE_W'(OP_LOAD));
    assign is_store = (opcode_i == OPCODE_W'(OP_STORE));
    assign is_beq   = (opcode_i == OPCODE_W'(OP_BEQ));
    assign is_addi  = (opcode_i == OPCODE_W'(OP_ADDI));

    always_comb begin
        ctrl_c_o   = '0;
        alu_op_c_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_c_o.imem_req = 1'b1;
                ctrl_c_o.ir_write = imem_ready_i;
                ctrl_c_o.pc_write = imem_ready_i;
            end
            EXECUTE: begin
                if (is_rtype) begin
                    alu_op_c_o = ALUOP_W'(opcode_i);
                end
                if (is_load || is_store || is_addi) begin
                    alu_op_c_o       = ALUOP_W'(ALU_ADD);
                    ctrl_c_o.alu_src = 1'b1;
                end
                if (is_beq) begin
                    alu_op_c_o      = ALUOP_W'(ALU_SUB);
                    ctrl_c_o.branch = 1'b1;
                end
            end
            MEM: begin
                // Address generation held for the whole access
                alu_op_c_o          = ALUOP_W'(ALU_ADD);
                ctrl_c_o.alu_src    = 1'b1;
                ctrl_c_o.mem_read   = is_load;
                ctrl_c_o.mem_write  = is_store;
            end
            WRITEBACK: begin
                ctrl_c_o.reg_write  = 1'b1;
                ctrl_c_o.reg_dst    = is_rtype;
                ctrl_c_o.mem_to_reg = is_load;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer with memory-wait timeout and illegal-opcode trap.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W       = 8,
    parameter int unsigned ALUOP_W        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                illegal_q, illegal_d;
    logic                bus_err_q, bus_err_d;
    logic                waiting;
    logic                timeout_hit;
    ctrl_t               ctrl;
    logic [ALUOP_W-1:0]  alu_op;

    assign waiting = ((state_q == FETCH) && !bus.imem_ready) ||
                     ((state_q == MEM)   && !bus.dmem_ready);

    // Limit counts the current low cycle too, so ready high on that cycle still wins
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && waiting &&
                         (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == LIMIT);

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        cnt_d     = '0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (bus.imem_ready) begin
                    state_d = DECODE;
                end else if (timeout_hit) begin
                    state_d   = TRAP;
                    bus_err_d = 1'b1;
                end
            end
            DECODE: begin
                opcode_d = bus.opcode;
                if (op_legal(32'(bus.opcode))) begin
                    state_d = EXECUTE;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXECUTE: begin
                if (opcode_q == OPCODE_W'(OP_BEQ)) begin
                    state_d = FETCH;
                end else if ((opcode_q == OPCODE_W'(OP_LOAD)) || (opcode_q == OPCODE_W'(OP_STORE))) begin
                    state_d = MEM;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEM: begin
                if (bus.dmem_ready) begin
                    state_d = (opcode_q == OPCODE_W'(OP_LOAD)) ? WRITEBACK : FETCH;
                end else if (timeout_hit) begin
                    state_d   = TRAP;
                    bus_err_d = 1'b1;
                end
            end
            WRITEBACK: state_d = FETCH;
            TRAP: begin
                if (bus.trap_clear) begin
                    state_d   = FETCH;
                    illegal_d = 1'b0;
                    bus_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Saturating wait counter, cleared on ready or any state change
        if (waiting && (state_d == state_q)) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decode (
        .state_i      (state_q),
        .opcode_i     (opcode_q),
        .imem_ready_i (bus.imem_ready),
        .ctrl_c_o     (ctrl),
        .alu_op_c_o   (alu_op)
    );

    assign bus.imem_req  = ctrl.imem_req;
    assign bus.irWrite   = ctrl.ir_write;
    assign bus.pcWrite   = ctrl.pc_write;
    assign bus.regDst    = ctrl.reg_dst;
    assign bus.branch    = ctrl.branch;
    assign bus.memRead   = ctrl.mem_read;
    assign bus.memToReg  = ctrl.mem_to_reg;
    assign bus.aluOp     = alu_op;
    assign bus.memWrite  = ctrl.mem_write;
    assign bus.aluSrc    = ctrl.alu_src;
    assign bus.regWrite  = ctrl.reg_write;
    assign bus.illegal   = illegal_q;
    assign bus.bus_error = bus_err_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: per-instruction expected cycle traces built from the latency/control rules.
module tb_multicycle_control;

    localparam int TO = 16;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

    localparam logic [31:0] IREQ = 32'h0008_0000, IRW = 32'h0004_0000, PCW = 32'h0002_0000,
                            RDST = 32'h0001_0000, BR  = 32'h0000_8000, MRD = 32'h0000_4000,
                            M2R  = 32'h0000_2000, MWR = 32'h0000_1000, ASRC = 32'h0000_0800,
                            RWR  = 32'h0000_0400;

    localparam logic [7:0] A_ADD = 8'h20, A_SUB = 8'h22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_control_if #(.OPCODE_W(8), .ALUOP_W(8)) bus ();

    multicycle_control #(
        .OPCODE_W       (8),
        .ALUOP_W        (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the full expected output word; -1 inputs are don't-care (random)
    typedef struct {
        logic [31:0] exp;
        int          imr;
        int          dmr;
        int          tc;
        int          op;
    } step_t;

    step_t sq[$];
    int    n_err = 0;
    int    n_chk = 0;
    int    cyc   = 0;
    bit    ill_m = 1'b0;
    bit    be_m  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {9'd0, bus.state_o, bus.imem_req, bus.irWrite, bus.pcWrite, bus.regDst,
                bus.branch, bus.memRead, bus.memToReg, bus.memWrite, bus.aluSrc,
                bus.regWrite, bus.illegal, bus.bus_error, bus.aluOp};
    endfunction

    function automatic bit legal(input int op);
        return (op >= 1) && (op <= 5);
    endfunction

    task automatic push(input logic [2:0] st, input logic [31:0] ctl, input logic [7:0] alu,
                        input int imr, input int dmr, input int tc, input int op);
        step_t s;
        s.exp = (32'(st) << 20) | ctl | (32'(ill_m) << 9) | (32'(be_m) << 8) | 32'(alu);
        s.imr = imr;
        s.dmr = dmr;
        s.tc  = tc;
        s.op  = op;
        sq.push_back(s);
    endtask

    // Trap sits with all controls low until a trap_clear cycle, which also clears the flags
    task automatic add_trap(input int hold);
        for (int i = 0; i < hold; i++) push(S_TRAP, 32'h0, 8'h0, -1, -1, 0, -1);
        push(S_TRAP, 32'h0, 8'h0, -1, -1, 1, -1);
        ill_m = 1'b0;
        be_m  = 1'b0;
    endtask

    task automatic add_instr(input int op, input int fw, input int mw, input int hold);
        logic [31:0] mctl;
        mctl = ASRC | ((op == 2) ? MRD : MWR);
        for (int i = 0; i < fw; i++) begin
            push(S_FETCH, IREQ, 8'h0, 0, -1, -1, -1);
            if (i == TO - 1) begin
                be_m = 1'b1;
                add_trap(hold);
                return;
            end
        end
        push(S_FETCH, IREQ | IRW | PCW, 8'h0, 1, -1, -1, -1);
        push(S_DECODE, 32'h0, 8'h0, -1, -1, -1, op);
        if (!legal(op)) begin
            ill_m = 1'b1;
            add_trap(hold);
            return;
        end
        case (op)
            1: begin
                push(S_EXEC, 32'h0, 8'(op), -1, -1, -1, -1);
                push(S_WB, RDST | RWR, 8'h0, -1, -1, -1, -1);
            end
            5: begin
                push(S_EXEC, ASRC, A_ADD, -1, -1, -1, -1);
                push(S_WB, RWR, 8'h0, -1, -1, -1, -1);
            end
            4: push(S_EXEC, BR, A_SUB, -1, -1, -1, -1);
            default: begin
                push(S_EXEC, ASRC, A_ADD, -1, -1, -1, -1);
                for (int i = 0; i < mw; i++) begin
                    push(S_MEM, mctl, A_ADD, -1, 0, -1, -1);
                    if (i == TO - 1) begin
                        be_m = 1'b1;
                        add_trap(hold);
                        return;
                    end
                end
                push(S_MEM, mctl, A_ADD, -1, 1, -1, -1);
                if (op == 2) push(S_WB, M2R | RWR, 8'h0, -1, -1, -1, -1);
            end
        endcase
    endtask

    task automatic drive_rand();
        bus.imem_ready = 1'($urandom);
        bus.dmem_ready = 1'($urandom);
        bus.trap_clear = 1'($urandom);
        bus.opcode     = 8'($urandom);
    endtask

    task automatic run_q();
        step_t s;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(negedge clk);
            drive_rand();
            if (s.imr >= 0) bus.imem_ready = 1'(s.imr);
            if (s.dmr >= 0) bus.dmem_ready = 1'(s.dmr);
            if (s.tc  >= 0) bus.trap_clear = 1'(s.tc);
            if (s.op  >= 0) bus.opcode     = 8'(s.op);
            #1;
            check($sformatf("cyc%0d", cyc), obs(), s.exp);
            cyc++;
        end
    endtask

    int op_r, fw_r, mw_r;

    initial begin
        bus.opcode     = 8'h0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.trap_clear = 1'b0;
        #1 check("reset", obs(), 32'h0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", obs(), 32'h0);
        @(negedge clk);
        drive_rand();
        rst_n = 1'b1;
        #1 check("idle", obs(), 32'h0);

        add_instr(1, 0, 0, 0);       // RTYPE, zero wait
        add_instr(2, 0, 3, 0);       // LOAD, 3 wait cycles
        add_instr(8'h7F, 0, 0, 1);   // illegal
        add_instr(1, 16, 0, 1);      // fetch timeout
        add_instr(5, 15, 0, 0);      // fetch ready on the limit cycle
        add_instr(4, 0, 0, 0);       // BEQ
        add_instr(3, 0, 16, 2);      // store timeout in MEM
        add_instr(2, 0, 15, 0);      // load ready on the limit cycle
        add_instr(0, 0, 0, 0);       // illegal just below range
        add_instr(6, 1, 0, 0);       // illegal just above range
        add_instr(3, 2, 1, 0);
        run_q();

        // STORE abandoned by reset during MEM
        push(S_FETCH, IREQ | IRW | PCW, 8'h0, 1, -1, -1, -1);
        push(S_DECODE, 32'h0, 8'h0, -1, -1, -1, 3);
        push(S_EXEC, ASRC, A_ADD, -1, -1, -1, -1);
        push(S_MEM, ASRC | MWR, A_ADD, -1, 0, -1, -1);
        push(S_MEM, ASRC | MWR, A_ADD, -1, 0, -1, -1);
        run_q();
        #1 rst_n = 1'b0;
        #1 check("rst_mid_mem", obs(), 32'h0);
        ill_m = 1'b0;
        be_m  = 1'b0;
        @(negedge clk);
        drive_rand();
        rst_n = 1'b1;
        #1 check("rst_release", obs(), 32'h0);
        add_instr(3, 0, 0, 0);
        run_q();

        for (int n = 0; n < 40; n++) begin
            case ($urandom % 8)
                0, 1, 2, 3, 4: op_r = int'($urandom_range(1, 5));
                5:             op_r = ($urandom % 4 == 0) ? 0 : int'($urandom_range(6, 255));
                default:       op_r = int'($urandom_range(1, 5));
            endcase
            fw_r = ($urandom % 10 == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 2));
            mw_r = ($urandom % 10 == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            add_instr(op_r, fw_r, mw_r, int'($urandom_range(0, 2)));
            run_q();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and emits the same datapath control set per state: regDst, branch, memRead, memToReg, aluOp, memWrite, aluSrc, regWrite.
- Adds instruction/data memory ready handshakes, a memory-wait timeout, and an illegal-opcode trap.
- Sits between the instruction register and the datapath muxes, register file and memories.

Parameters:
- OPCODE_W, 8, opcode width; must be <= ALUOP_W.
- ALUOP_W, 8, aluOp width.
- TIMEOUT_CYCLES, 16, max consecutive ready-low cycles in FETCH or MEM; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  opcode field from instruction register output.
- imem_ready  in  1  instruction memory returns data this cycle.
- dmem_ready  in  1  data memory completes access this cycle.
- trap_clear  in  1  leave TRAP, resume fetching.
- imem_req  out  1  instruction fetch request.
- irWrite  out  1  load instruction register.
- pcWrite  out  1  increment PC.
- regDst  out  1  destination register = rd (1) / rt (0).
- branch  out  1  branch compare qualify.
- memRead  out  1  data memory read.
- memToReg  out  1  writeback from memory.
- aluOp  out  ALUOP_W  ALU operation.
- memWrite  out  1  data memory write.
- aluSrc  out  1  ALU B = immediate.
- regWrite  out  1  register file write enable.
- illegal  out  1  sticky: undefined opcode seen.
- bus_error  out  1  sticky: memory timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; opcode_q = 0; wait counter = 0; illegal = 0; bus_error = 0.
  - All outputs 0 in the same cycle.
  - Reset mid-instruction abandons the instruction; no partial writes continue.
- IDLE: unconditionally -> FETCH on the next edge.
- FETCH:
  - imem_req = 1.
  - irWrite = pcWrite = imem_ready (combinational qualify).
  - -> DECODE when imem_ready.
- DECODE:
  - opcode_q <= opcode.
  - Defined opcode -> EXECUTE; otherwise -> TRAP and illegal <= 1.
- EXECUTE:
  - aluOp = zero-extended opcode_q for RTYPE; ALU_ADD for LOAD, STORE and ADDI; ALU_SUB for BEQ.
  - aluSrc = 1 for LOAD, STORE and ADDI.
  - branch = 1 for BEQ.
  - Next state: BEQ -> FETCH; LOAD/STORE -> MEM; RTYPE/ADDI -> WRITEBACK.
- MEM:
  - aluSrc = 1 and aluOp = ALU_ADD held.
  - memRead (LOAD) or memWrite (STORE) held until dmem_ready.
  - On dmem_ready: LOAD -> WRITEBACK; STORE -> FETCH.
- WRITEBACK:
  - regWrite = 1.
  - regDst = 1 for RTYPE; memToReg = 1 for LOAD.
  - -> FETCH.
- TRAP:
  - All control outputs 0; flags held.
  - trap_clear -> FETCH, and illegal and bus_error clear on that edge.
- Default rule: any control output not listed for a state is 0, including aluOp.
- Latency with zero-wait memory (cycles from FETCH entry to next FETCH): BEQ 3, STORE 4, RTYPE 4, ADDI 4, LOAD 5.
- Timeout:
  - Wait counter increments each FETCH/MEM cycle with ready low; clears on ready or on state change.
  - When the counter reaches TIMEOUT_CYCLES with ready still low -> TRAP and bus_error <= 1.
  - Ready high in the same cycle the limit is reached: ready wins, no error.
  - Counter width = clog2(TIMEOUT_CYCLES+1) and never wraps.
- Fault flags set only outside TRAP, so set and clear never coincide.
- trap_clear outside TRAP is ignored.

Decomposition:
- Shared package ctrl_pkg holds:
  - Opcode constants: OP_RTYPE = 1, OP_LOAD = 2, OP_STORE = 3, OP_BEQ = 4, OP_ADDI = 5.
  - ALU constants: ALU_ADD = 8'h20, ALU_SUB = 8'h22.
  - State enum: IDLE = 0, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- One natural sub-module, ctrl_decode: purely combinational (state, opcode_q) -> control vector. The FSM and timeout counter stay in the top module.

Test Plan:
1. Reset then RTYPE (opcode 8'h01), both ready held 1 -> state_o sequence IDLE, FETCH, DECODE, EXECUTE, WRITEBACK; aluOp = 8'h01 in EXECUTE; regDst = regWrite = 1 in WRITEBACK; back to FETCH after 4 cycles.
2. LOAD (8'h02) with dmem_ready low for 3 cycles -> memRead = 1 held for 4 MEM cycles, aluSrc = 1; then WRITEBACK with memToReg = regWrite = 1; bus_error stays 0.
3. Opcode 8'h7F -> TRAP after DECODE, illegal = 1, all controls 0; trap_clear pulse -> FETCH next cycle, illegal = 0.
4. TIMEOUT_CYCLES = 16, imem_ready held 0 -> TRAP with bus_error = 1 after 16 FETCH cycles; repeat with imem_ready rising on cycle 16 -> DECODE, no error.
5. Assert rst_n low mid-MEM of a STORE (8'h03) -> memWrite drops to 0 asynchronously, state_o = IDLE; after release, FETCH resumes.
6. BEQ (8'h04) -> branch = 1 and aluOp = ALU_SUB for exactly one EXECUTE cycle, then FETCH; regWrite never asserted.
